// File: rtl/calc_seq_if.sv
// Bus and ALU handshake bundle between calc_seq, the keypad entry block and the ALU.
// calc_seq connects through the master modport.
interface calc_seq_if;
    logic        OUT_wr;
    logic [7:0]  IN_SRCH;
    logic [7:0]  IN_SRCL;
    logic [7:0]  IN_DSTH;
    logic [7:0]  IN_DSTL;
    logic [7:0]  IN_ALU_OP;
    logic [7:0]  IN_ctrl;
    logic        OUT_alu_start;
    logic [15:0] OUT_alu_a;
    logic [15:0] OUT_alu_b;
    logic [3:0]  OUT_alu_op;
    logic        IN_alu_done;
    logic [15:0] IN_alu_result;
    logic        IN_alu_err;

    modport master (
        output OUT_wr, OUT_alu_start, OUT_alu_a, OUT_alu_b, OUT_alu_op,
        input  IN_SRCH, IN_SRCL, IN_DSTH, IN_DSTL, IN_ALU_OP, IN_ctrl,
        input  IN_alu_done, IN_alu_result, IN_alu_err
    );

    modport slave (
        input  OUT_wr, OUT_alu_start, OUT_alu_a, OUT_alu_b, OUT_alu_op,
        output IN_SRCH, IN_SRCL, IN_DSTH, IN_DSTL, IN_ALU_OP, IN_ctrl,
        output IN_alu_done, IN_alu_result, IN_alu_err
    );
endinterface

// File: rtl/calc_seq.sv
// Polls the keypad entry bus, issues one ALU operation per rising "finish",
// and holds the result (or error) for the display path.
module calc_seq #(
    parameter int unsigned POLL_DIV = 16,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        IN_clk,
    input  logic        IN_reset,
    calc_seq_if.master  bus,
    output logic [15:0] OUT_result,
    output logic        OUT_valid,
    output logic        OUT_err,
    output logic        OUT_busy
);
    localparam int unsigned PC_W = $clog2(POLL_DIV);
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_SAMPLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic [PC_W-1:0] poll_cnt, poll_nxt;
    logic [WD_W-1:0] wd_cnt, wd_nxt;
    logic [15:0] a_q, a_nxt, b_q, b_nxt;
    logic [3:0]  op_q, op_nxt;
    logic        prev_fin, prev_fin_nxt;
    logic        wr_q, wr_nxt;
    logic [15:0] result_q, result_nxt;
    logic        valid_q, valid_nxt;
    logic        err_q, err_nxt;

    logic        fin;
    logic [3:0]  op_in;
    logic        op_ok;
    logic        unused_bits;

    assign fin         = bus.IN_ctrl[7];
    assign op_in       = bus.IN_ALU_OP[3:0];
    assign op_ok       = (op_in >= 4'hA) && (op_in <= 4'hE);
    assign unused_bits = ^{bus.IN_ALU_OP[7:4], bus.IN_ctrl[6:0]};

    always_ff @(posedge IN_clk or negedge IN_reset) begin
        if (!IN_reset) begin
            state    <= ST_IDLE;
            poll_cnt <= '0;
            wd_cnt   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            prev_fin <= 1'b0;
            wr_q     <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            poll_cnt <= poll_nxt;
            wd_cnt   <= wd_nxt;
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            op_q     <= op_nxt;
            prev_fin <= prev_fin_nxt;
            wr_q     <= wr_nxt;
            result_q <= result_nxt;
            valid_q  <= valid_nxt;
            err_q    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        poll_nxt     = poll_cnt;
        wd_nxt       = wd_cnt;
        a_nxt        = a_q;
        b_nxt        = b_q;
        op_nxt       = op_q;
        prev_fin_nxt = prev_fin;
        result_nxt   = result_q;
        valid_nxt    = valid_q;
        err_nxt      = err_q;

        case (state)
            ST_IDLE: begin
                // Counter is left at zero on exit, so each IDLE visit restarts the poll period.
                if (poll_cnt == PC_W'(POLL_DIV - 1)) begin
                    poll_nxt  = '0;
                    state_nxt = ST_POLL;
                end else begin
                    poll_nxt = poll_cnt + PC_W'(1);
                end
            end
            ST_POLL: state_nxt = ST_SAMPLE;
            ST_SAMPLE: begin
                a_nxt        = {bus.IN_SRCH, bus.IN_SRCL};
                b_nxt        = {bus.IN_DSTH, bus.IN_DSTL};
                op_nxt       = op_in;
                prev_fin_nxt = fin;
                state_nxt    = ST_IDLE;
                if (fin && !prev_fin) begin
                    if (op_ok) begin
                        state_nxt = ST_ISSUE;
                    end else begin
                        err_nxt   = 1'b1;
                        valid_nxt = 1'b1;
                    end
                end else if (!fin) begin
                    err_nxt   = 1'b0;
                    valid_nxt = 1'b0;
                end
            end
            ST_ISSUE: begin
                wd_nxt    = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Done is checked first so a completion in the final cycle still wins.
                if (bus.IN_alu_done) begin
                    result_nxt = bus.IN_alu_result;
                    err_nxt    = bus.IN_alu_err;
                    valid_nxt  = 1'b1;
                    state_nxt  = ST_IDLE;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wd_nxt = wd_cnt + WD_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        wr_nxt = (state_nxt == ST_POLL) || (state_nxt == ST_SAMPLE);
    end

    assign bus.OUT_wr        = wr_q;
    assign bus.OUT_alu_start = (state == ST_ISSUE);
    assign bus.OUT_alu_a     = a_q;
    assign bus.OUT_alu_b     = b_q;
    assign bus.OUT_alu_op    = op_q;

    assign OUT_result = result_q;
    assign OUT_valid  = valid_q;
    assign OUT_err    = err_q;
    assign OUT_busy   = (state == ST_ISSUE) || (state == ST_WAIT);
endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq: drives the entry bus and plays the ALU by hand,
// checking each step against hand-computed values.
module tb_calc_seq;
    logic        IN_clk   = 1'b0;
    logic        IN_reset = 1'b1;
    logic [15:0] OUT_result;
    logic        OUT_valid;
    logic        OUT_err;
    logic        OUT_busy;

    int total  = 0;
    int bad    = 0;
    int starts = 0;
    int base;

    calc_seq_if bus ();

    calc_seq #(.POLL_DIV(8), .TIMEOUT(8)) dut (
        .IN_clk     (IN_clk),
        .IN_reset   (IN_reset),
        .bus        (bus),
        .OUT_result (OUT_result),
        .OUT_valid  (OUT_valid),
        .OUT_err    (OUT_err),
        .OUT_busy   (OUT_busy)
    );

    always #5 IN_clk = ~IN_clk;

    always @(negedge IN_clk) begin
        if (bus.OUT_alu_start === 1'b1) starts++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge IN_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] op, input logic fin);
        bus.IN_SRCH   = a[15:8];
        bus.IN_SRCL   = a[7:0];
        bus.IN_DSTH   = b[15:8];
        bus.IN_DSTL   = b[7:0];
        bus.IN_ALU_OP = {4'h5, op};
        bus.IN_ctrl   = {fin, 2'b10, 5'h00};
    endtask

    // Leaves the bench in the cycle right after SAMPLE (ISSUE or IDLE).
    task automatic poll();
        bit seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.OUT_wr === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        chk("poll_seen", {31'd0, seen}, 32'd1);
        tick(1);
        chk("wr_in_sample", {31'd0, bus.OUT_wr}, 32'd1);
        tick(1);
        chk("wr_dropped", {31'd0, bus.OUT_wr}, 32'd0);
    endtask

    task automatic pulse_done(input logic [15:0] res, input logic err);
        bus.IN_alu_done   = 1'b1;
        bus.IN_alu_result = res;
        bus.IN_alu_err    = err;
        tick(1);
        bus.IN_alu_done   = 1'b0;
        bus.IN_alu_result = 16'h0000;
        bus.IN_alu_err    = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr"},     {31'd0, bus.OUT_wr}, 32'd0);
        chk({tag, "_start"},  {31'd0, bus.OUT_alu_start}, 32'd0);
        chk({tag, "_a"},      {16'd0, bus.OUT_alu_a}, 32'd0);
        chk({tag, "_b"},      {16'd0, bus.OUT_alu_b}, 32'd0);
        chk({tag, "_op"},     {28'd0, bus.OUT_alu_op}, 32'd0);
        chk({tag, "_result"}, {16'd0, OUT_result}, 32'd0);
        chk({tag, "_valid"},  {31'd0, OUT_valid}, 32'd0);
        chk({tag, "_err"},    {31'd0, OUT_err}, 32'd0);
        chk({tag, "_busy"},   {31'd0, OUT_busy}, 32'd0);
    endtask

    initial begin
        bus.IN_alu_done   = 1'b0;
        bus.IN_alu_result = 16'h0000;
        bus.IN_alu_err    = 1'b0;
        set_bus(16'h0000, 16'h0000, 4'h0, 1'b0);

        // Reset
        #2 IN_reset = 1'b0;
        #1 chk_all_zero("reset");
        tick(2);
        IN_reset = 1'b1;

        // First operation: 0x007B op A 0x0003, ALU answers 0x007E
        set_bus(16'h007B, 16'h0003, 4'hA, 1'b1);
        poll();
        chk("t1_start", {31'd0, bus.OUT_alu_start}, 32'd1);
        chk("t1_busy",  {31'd0, OUT_busy}, 32'd1);
        chk("t1_a",     {16'd0, bus.OUT_alu_a}, 32'h007B);
        chk("t1_b",     {16'd0, bus.OUT_alu_b}, 32'h0003);
        chk("t1_op",    {28'd0, bus.OUT_alu_op}, 32'hA);
        tick(1);
        chk("t1_start_one_cycle", {31'd0, bus.OUT_alu_start}, 32'd0);
        chk("t1_busy_wait",       {31'd0, OUT_busy}, 32'd1);
        tick(2);
        pulse_done(16'h007E, 1'b0);
        chk("t1_result", {16'd0, OUT_result}, 32'h007E);
        chk("t1_valid",  {31'd0, OUT_valid}, 32'd1);
        chk("t1_err",    {31'd0, OUT_err}, 32'd0);
        chk("t1_busy",   {31'd0, OUT_busy}, 32'd0);

        // Finish held high: no reissue
        base = starts;
        repeat (5) poll();
        chk("hold_no_reissue", starts - base, 32'd0);
        chk("hold_valid",      {31'd0, OUT_valid}, 32'd1);

        // Finish 1 -> 0 -> 1 with new opcode
        set_bus(16'h007B, 16'h0003, 4'hA, 1'b0);
        poll();
        chk("fin0_valid_clr", {31'd0, OUT_valid}, 32'd0);
        chk("fin0_err_clr",   {31'd0, OUT_err}, 32'd0);
        chk("fin0_no_start",  {31'd0, bus.OUT_alu_start}, 32'd0);
        set_bus(16'h1234, 16'h0042, 4'hD, 1'b1);
        poll();
        chk("t2_start", {31'd0, bus.OUT_alu_start}, 32'd1);
        chk("t2_op",    {28'd0, bus.OUT_alu_op}, 32'hD);
        chk("t2_a",     {16'd0, bus.OUT_alu_a}, 32'h1234);
        chk("t2_b",     {16'd0, bus.OUT_alu_b}, 32'h0042);
        tick(1);
        pulse_done(16'h1276, 1'b0);
        chk("t2_result", {16'd0, OUT_result}, 32'h1276);
        chk("t2_valid",  {31'd0, OUT_valid}, 32'd1);

        // Watchdog timeout (TIMEOUT = 8)
        set_bus(16'h0001, 16'h0002, 4'hB, 1'b0);
        poll();
        set_bus(16'h0001, 16'h0002, 4'hB, 1'b1);
        poll();
        chk("to_start", {31'd0, bus.OUT_alu_start}, 32'd1);
        tick(8);
        chk("to_not_yet_valid", {31'd0, OUT_valid}, 32'd0);
        chk("to_not_yet_busy",  {31'd0, OUT_busy}, 32'd1);
        tick(1);
        chk("to_valid",  {31'd0, OUT_valid}, 32'd1);
        chk("to_err",    {31'd0, OUT_err}, 32'd1);
        chk("to_result", {16'd0, OUT_result}, 32'h1276);
        chk("to_busy",   {31'd0, OUT_busy}, 32'd0);

        // Illegal opcodes 0xF and 0x9
        set_bus(16'h0001, 16'h0002, 4'hF, 1'b0);
        poll();
        chk("badf_pre_err", {31'd0, OUT_err}, 32'd0);
        set_bus(16'h0001, 16'h0002, 4'hF, 1'b1);
        poll();
        chk("badf_no_start", {31'd0, bus.OUT_alu_start}, 32'd0);
        chk("badf_busy",     {31'd0, OUT_busy}, 32'd0);
        chk("badf_err",      {31'd0, OUT_err}, 32'd1);
        chk("badf_valid",    {31'd0, OUT_valid}, 32'd1);
        chk("badf_result",   {16'd0, OUT_result}, 32'h1276);
        set_bus(16'h0001, 16'h0002, 4'h9, 1'b0);
        poll();
        set_bus(16'h0001, 16'h0002, 4'h9, 1'b1);
        poll();
        chk("bad9_no_start", {31'd0, bus.OUT_alu_start}, 32'd0);
        chk("bad9_err",      {31'd0, OUT_err}, 32'd1);

        // Done in ISSUE ignored; done coincident with watchdog expiry wins
        set_bus(16'h00FF, 16'h0F00, 4'hC, 1'b0);
        poll();
        set_bus(16'h00FF, 16'h0F00, 4'hC, 1'b1);
        poll();
        chk("co_start", {31'd0, bus.OUT_alu_start}, 32'd1);
        pulse_done(16'hDEAD, 1'b1);
        chk("issue_done_ignored_busy",  {31'd0, OUT_busy}, 32'd1);
        chk("issue_done_ignored_valid", {31'd0, OUT_valid}, 32'd0);
        tick(7);
        chk("co_busy_last", {31'd0, OUT_busy}, 32'd1);
        pulse_done(16'hBEEF, 1'b0);
        chk("co_result", {16'd0, OUT_result}, 32'hBEEF);
        chk("co_err",    {31'd0, OUT_err}, 32'd0);
        chk("co_valid",  {31'd0, OUT_valid}, 32'd1);
        chk("co_busy",   {31'd0, OUT_busy}, 32'd0);

        // Reset during WAIT, late done ignored, next rising finish processed
        set_bus(16'h0A0A, 16'h0505, 4'hE, 1'b0);
        poll();
        set_bus(16'h0A0A, 16'h0505, 4'hE, 1'b1);
        poll();
        chk("rw_start", {31'd0, bus.OUT_alu_start}, 32'd1);
        tick(2);
        chk("rw_busy", {31'd0, OUT_busy}, 32'd1);
        #2 IN_reset = 1'b0;
        #1 chk_all_zero("rw_async");
        tick(2);
        IN_reset = 1'b1;
        tick(1);
        pulse_done(16'h7777, 1'b1);
        chk("late_done_valid",  {31'd0, OUT_valid}, 32'd0);
        chk("late_done_err",    {31'd0, OUT_err}, 32'd0);
        chk("late_done_result", {16'd0, OUT_result}, 32'h0000);
        chk("late_done_busy",   {31'd0, OUT_busy}, 32'd0);
        poll();
        chk("rr_start", {31'd0, bus.OUT_alu_start}, 32'd1);
        chk("rr_a",     {16'd0, bus.OUT_alu_a}, 32'h0A0A);
        chk("rr_b",     {16'd0, bus.OUT_alu_b}, 32'h0505);
        chk("rr_op",    {28'd0, bus.OUT_alu_op}, 32'hE);
        tick(1);
        pulse_done(16'h0F0F, 1'b0);
        chk("rr_result", {16'd0, OUT_result}, 32'h0F0F);
        chk("rr_valid",  {31'd0, OUT_valid}, 32'd1);

        tick(1);
        chk("start_total", starts, 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
